// File: rtl/uart_access_arbiter.sv
// uart_access_arbiter: shares one uart register interface between two cores.
// Round-robin grant, owns the cr/tdr holding registers, and stretches each
// uart strobe then waits out the uart's falling-edge detectors before acking.
//
// Handshake: a core raises req with we/addr/wdata and holds them stable until
// its one-cycle ack pulse; rdata is valid in the ack cycle and held until that
// core's next read. A req still high in the IDLE cycle after ack is a new
// request. A non-granted req simply stays pending.
module uart_access_arbiter #(
    parameter int unsigned STROBE_CYCLES  = 2,
    parameter int unsigned RECOVER_CYCLES = 3,
    parameter logic [31:0] CR_RESET       = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [1:0]  addr0,
    input  logic [1:0]  addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic [31:0] cr,
    output logic [31:0] tdr,
    output logic        tx_write,
    output logic        rx_read,
    output logic        sr_read,
    input  logic [31:0] sr,
    input  logic [31:0] rdr,
    output logic [2:0]  dbg_state_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GRANT   = 3'd1,
        STROBE  = 3'd2,
        RECOVER = 3'd3,
        ACK     = 3'd4
    } state_e;

    localparam logic [1:0] A_CR  = 2'd0;
    localparam logic [1:0] A_SR  = 2'd1;
    localparam logic [1:0] A_TDR = 2'd2;
    localparam logic [1:0] A_RDR = 2'd3;

    localparam logic [3:0] STB_LOAD = 4'(STROBE_CYCLES - 1);
    localparam logic [3:0] REC_LOAD = 4'(RECOVER_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        gid_q, gid_d;
    logic        last_grant_q, last_grant_d;
    logic        we_q, we_d;
    logic [1:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] cr_q, cr_d;
    logic [31:0] tdr_q, tdr_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;
    logic        tx_q, tx_d;
    logic        rx_q, rx_d;
    logic        srr_q, srr_d;
    logic        pick;
    logic        rd_en;
    logic [31:0] rd_val;

    // State and datapath registers; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            gid_q        <= 1'b0;
            last_grant_q <= 1'b1;
            we_q         <= 1'b0;
            addr_q       <= 2'd0;
            wdata_q      <= 32'd0;
            cr_q         <= CR_RESET;
            tdr_q        <= 32'd0;
            rdata0_q     <= 32'd0;
            rdata1_q     <= 32'd0;
            tx_q         <= 1'b0;
            rx_q         <= 1'b0;
            srr_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            gid_q        <= gid_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cr_q         <= cr_d;
            tdr_q        <= tdr_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            tx_q         <= tx_d;
            rx_q         <= rx_d;
            srr_q        <= srr_d;
        end
    end

    // Next-state logic: arbitration, register access decode, strobe timing.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        gid_d        = gid_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cr_d         = cr_q;
        tdr_d        = tdr_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        tx_d         = tx_q;
        rx_d         = rx_q;
        srr_d        = srr_q;
        rd_en        = 1'b0;
        rd_val       = 32'd0;
        // On a tie the core that did not win last time is served.
        pick         = (req0 && req1) ? ~last_grant_q : req1;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    gid_d   = pick;
                    we_d    = pick ? we1 : we0;
                    addr_d  = pick ? addr1 : addr0;
                    wdata_d = pick ? wdata1 : wdata0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                state_d = ACK;
                case (addr_q)
                    A_CR: begin
                        if (we_q) begin
                            cr_d = wdata_q;
                        end else begin
                            rd_en  = 1'b1;
                            rd_val = cr_q;
                        end
                    end
                    A_SR: begin
                        if (!we_q) begin
                            rd_en   = 1'b1;
                            rd_val  = sr;
                            srr_d   = 1'b1;
                            cnt_d   = STB_LOAD;
                            state_d = STROBE;
                        end
                    end
                    A_TDR: begin
                        if (we_q) begin
                            tdr_d   = wdata_q;
                            tx_d    = 1'b1;
                            cnt_d   = STB_LOAD;
                            state_d = STROBE;
                        end else begin
                            rd_en  = 1'b1;
                            rd_val = tdr_q;
                        end
                    end
                    default: begin
                        // Capture the FIFO head before the pop strobe.
                        if (!we_q) begin
                            rd_en   = 1'b1;
                            rd_val  = rdr;
                            rx_d    = 1'b1;
                            cnt_d   = STB_LOAD;
                            state_d = STROBE;
                        end
                    end
                endcase
                if (rd_en) begin
                    if (gid_q) begin
                        rdata1_d = rd_val;
                    end else begin
                        rdata0_d = rd_val;
                    end
                end
            end
            STROBE: begin
                if (cnt_q == 4'd0) begin
                    tx_d    = 1'b0;
                    rx_d    = 1'b0;
                    srr_d   = 1'b0;
                    cnt_d   = REC_LOAD;
                    state_d = RECOVER;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RECOVER: begin
                if (cnt_q == 4'd0) begin
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ACK: begin
                last_grant_d = gid_q;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ack0        = (state_q == ACK) && !gid_q;
    assign ack1        = (state_q == ACK) && gid_q;
    assign rdata0      = rdata0_q;
    assign rdata1      = rdata1_q;
    assign cr          = cr_q;
    assign tdr         = tdr_q;
    assign tx_write    = tx_q;
    assign rx_read     = rx_q;
    assign sr_read     = srr_q;
    assign dbg_state_o = state_q;

endmodule

// File: doc/uart_access_arbiter.md
Name: uart_access_arbiter

Overview:
- Shares one uart instance's register interface (cr, tdr, rdr, sr, tx_write, rx_read, sr_read) between the two CPU cores of the dual-core system.
- Per-core request/ack handshake with round-robin arbitration.
- Owns the cr and tdr holding registers.
- Generates width-controlled tx_write / rx_read / sr_read strobes, then waits out the uart's falling-edge detectors before acknowledging the core.

Parameters:
- STROBE_CYCLES, 2, cycles each uart strobe stays high; legal range 1..15.
- RECOVER_CYCLES, 3, idle cycles after strobe falls before ack; legal range 3..15. Covers the 2-flop falling-edge detect plus the status update.
- CR_RESET, 32'h0000_0000, reset value of the cr output.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req0, req1  in  1 each  core access request, held until ack.
- we0, we1  in  1 each  1 = write, 0 = read.
- addr0, addr1  in  2 each  register select: 0 = CR, 1 = SR, 2 = TDR, 3 = RDR.
- wdata0, wdata1  in  32 each  write data.
- ack0, ack1  out  1 each  one-cycle completion pulse.
- rdata0, rdata1  out  32 each  read data, valid in the ack cycle and held until that core's next read.
- cr  out  32  uart control register.
- tdr  out  32  uart transmit data register.
- tx_write, rx_read, sr_read  out  1 each  uart access strobes.
- sr  in  32  uart status.
- rdr  in  32  uart receive data.

Behaviour:
- Reset, asynchronous, effective immediately:
  - cr = CR_RESET; tdr, rdata0, rdata1 = 0.
  - All strobes and acks = 0.
  - FSM = IDLE; last_grant = 1, so core0 wins the first tie.
- FSM states: IDLE, GRANT, STROBE, RECOVER, ACK.
- IDLE:
  - If only one req is high, latch that core's id, we, addr and wdata; go to GRANT.
  - If both are high, grant the core not equal to last_grant.
  - If neither is high, stay.
- GRANT, exactly one cycle:
  - Write CR: cr <= wdata; go to ACK.
  - Write TDR: tdr <= wdata; go to STROBE with tx_write.
  - Read CR: rdata <= cr; go to ACK.
  - Read TDR: rdata <= tdr; go to ACK.
  - Read SR: capture sr into rdata; go to STROBE with sr_read.
  - Read RDR: capture rdr into rdata (pre-pop head of FIFO); go to STROBE with rx_read.
  - Write SR or write RDR: ignored, no strobe; go to ACK.
  - rdata updates only for the granted core.
- STROBE:
  - The selected strobe is registered high for exactly STROBE_CYCLES cycles; the other strobes stay 0.
  - Go to RECOVER.
- RECOVER: all strobes 0 for RECOVER_CYCLES cycles; go to ACK.
- ACK:
  - Pulse the granted core's ack for one cycle.
  - last_grant <= granted id; go to IDLE.
- Latency, with req seen high in IDLE at cycle 0:
  - Non-strobe access: ack at cycle 2.
  - Strobe access: strobe high in cycles 2..STROBE_CYCLES+1; ack at cycle STROBE_CYCLES+RECOVER_CYCLES+2 (cycle 7 with defaults).
- Handshake rules:
  - A requester holds req/we/addr/wdata stable until ack.
  - A requester drives req low in the cycle after ack unless it is issuing a new access. A req still high in that IDLE cycle is treated as a new request.
  - Non-granted req is ignored and stays pending; it is never dropped.
- Only one access is in flight at a time. At most one strobe is high in any cycle, and strobes never overlap across accesses.
- Counters are 4 bits, load value - 1, and decrement to 0.
- A reset asserted mid-access aborts it: no ack is issued, cr/tdr revert to reset values, and strobes drop asynchronously.
- Changes to input words after GRANT have no effect on the access in flight.

Test Plan:
- Reset: assert rst_n=0 mid-STROBE -> tx_write drops to 0 immediately; cr=0, tdr=0, ack0=ack1=0; after release, the first access completes normally.
- CR write, core0: req0, we0=1, addr0=0, wdata0=32'h0101_0003 -> cr=32'h0101_0003 from cycle 2; ack0 at cycle 2; no strobe asserted.
- TDR write, core1, defaults: addr1=2, wdata1=32'h41 -> tdr=32'h41; tx_write high in cycles 2-3 only; ack1 at cycle 7.
- RDR read with rdr=32'h5A: core0 read addr=3 -> rdata0=32'h5A at ack; rx_read high for 2 cycles; a later change of rdr does not alter rdata0.
- Contention: req0 and req1 both high from reset -> core0 served first (ack0), then core1 (ack1). Repeat with both held -> grants alternate 1,0,1 and neither core starves.
- Parameter check: STROBE_CYCLES=1, RECOVER_CYCLES=5, SR read -> sr_read high for exactly 1 cycle; ack at cycle 8; rdata equals sr sampled in GRANT.
